lsu_bus_bridge: RTL and testbench
=================================

# lsu_bus_bridge

Converts the core's single-cycle load/store strobes into a registered req/ack bus transaction for wait-state peripherals. Sits directly downstream of the RISC-V core's EX-stage memory port. Holds the pipeline through the core's `stall_req` input until the access completes. Generates byte enables and lane-replicated write data, and returns a registered read word.

## Interface
- `TIMEOUT_CYCLES`, default 255: bus cycles without `bus_ack` before forced completion. Used only with the timeout feature; legal range 1..65535.
- `clk` input 1: system clock; all logic on the rising edge.
- `rst_sync` input 1: synchronous, active-high reset.
- `access_ram_read` input 1: core load strobe, level, held while the core is stalled.
- `access_ram_write` input 1: core store strobe, level, held while the core is stalled.
- `access_ram_write_width` input 2: store size.
  - 00 byte, 01 half, 10 word.
  - 11 is treated as word.
- `access_ram_raddr` input 32: load address.
- `access_ram_waddr` input 32: store address.
- `access_ram_wdata` input 32: store data, right-justified.
- `access_ram_rdata` output 32: registered read word, full 32 bits; the core does the extraction.
- `stall_req` output 1: pipeline stall request into the core.
- `core_stall_n` input 1: core's global advance signal; 1 means the pipeline advances this edge.
- `bus_req` output 1: transaction request, registered.
- `bus_we` output 1: 1 = write.
- `bus_addr` output 32: word-aligned address, bits [1:0] = 0.
- `bus_be` output 4: byte enables; 4'b0000 on reads.
- `bus_wdata` output 32: lane-replicated store data.
- `bus_ack` input 1: slave completion; sampled only while `bus_req`=1.
- `bus_rdata` input 32: read data, valid with `bus_ack` on reads.
- `bus_timeout` output 1: one-cycle pulse when a transaction is force-completed.

## Operation
- Reset values:
  - state IDLE.
  - `bus_req`, `bus_we`, `bus_be`, `bus_timeout` = 0.
  - `bus_addr`, `bus_wdata`, `access_ram_rdata` = 0.
- `stall_req` is combinational:
  - In IDLE: (`access_ram_read` | `access_ram_write`).
  - In RD, WR: 1.
  - In DONE: 0.
- States:
  - IDLE:
    - If read is asserted: latch addresses, data and width, then go to RD.
    - Else if write is asserted: go to WR.
  - RD:
    - `bus_req`=1, `bus_we`=0.
    - On `bus_ack`: capture `bus_rdata` into `access_ram_rdata`.
    - Then go to WR if a write was latched together with the read, else go to DONE.
  - WR:
    - `bus_req`=1, `bus_we`=1.
    - On `bus_ack`: go to DONE.
  - DONE:
    - Wait until `core_stall_n`=1 is sampled, then go to IDLE.
    - The core's strobes are still high in DONE. DONE must not reissue the access even if another stall source holds the pipeline for many cycles.
- Simultaneous read and write: both are latched in IDLE. The read is performed first, then the write. `stall_req` stays high until the write is acked.
- Byte enables (from latched `waddr[1:0]`):
  - byte: 4'b0001 << a[1:0].
  - half: 4'b0011 << {a[1],1'b0}.
  - word: 4'b1111.
- Misalignment is the core's exception responsibility; the bridge silently masks the low bits.
- Write data replication:
  - byte: {4{d[7:0]}}.
  - half: {2{d[15:0]}}.
  - word: d.
- `bus_addr`, `bus_we`, `bus_be` and `bus_wdata` are registered and stable for the whole time `bus_req`=1.
- `access_ram_rdata` holds its last captured value until the next read ack.
- Reset mid-transaction: on the next edge, go to IDLE with `bus_req`=0. No ack is awaited; a late `bus_ack` is ignored.

## Timing
- Cycle 0: core raises a strobe in IDLE; `stall_req`=1 combinationally.
- Cycle 1: `bus_req`=1. A zero-wait slave may assert `bus_ack` in this cycle.
- Cycle 2: DONE, `stall_req`=0, `access_ram_rdata` valid. Core advances at the end of cycle 2.
- Minimum load/store: 3 core cycles. Each slave wait state adds 1 cycle.
- Combined read and write with zero-wait slaves: 4 cycles.
- `bus_req` drops on the edge after `bus_ack`. There are no back-to-back transactions without passing through DONE → IDLE.

## Configuration
- Macro: `LSU_BRIDGE_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on entry to RD/WR and increments each cycle that `bus_req`=1 and `bus_ack`=0.
  - When the count reaches `TIMEOUT_CYCLES`, the transaction completes as if acked.
  - A timed-out read returns `access_ram_rdata`=32'h0000_0000.
  - `bus_timeout` pulses 1 cycle, coincident with the forced completion edge.
- Undefined: no counter; `bus_timeout` is tied to 0; a hung slave stalls the core indefinitely.

## Test plan
- Zero-wait word load:
  - Stimulus: raddr=0x1000_0006, slave acks in the req cycle with rdata=0xCAFE_F00D.
  - Response: `bus_addr`=0x1000_0004, `bus_be`=0, stall high for 2 cycles, `access_ram_rdata`=0xCAFE_F00D in cycle 2.
- Byte store:
  - Stimulus: waddr=0x0000_0013, width=00, wdata=0x0000_00A5, 3 wait states.
  - Response: `bus_be`=4'b1000, `bus_wdata`=0xA5A5_A5A5, stall for 5 cycles.
- Simultaneous read and write:
  - Stimulus: raddr=0x20, waddr=0x24 half, zero-wait slave.
  - Response: read req, then write req with `bus_be`=4'b0011, 4 cycles total, no duplicate requests.
- External stall in DONE:
  - Stimulus: `core_stall_n`=0 for 6 cycles after ack.
  - Response: exactly one `bus_req` pulse, state held in DONE, IDLE after `core_stall_n`=1.
- Reset mid-transaction:
  - Stimulus: `rst_sync` in RD wait.
  - Response: next cycle `bus_req`=0, all outputs at reset values, a later stray `bus_ack` ignored.
- Timeout (macro defined, `TIMEOUT_CYCLES`=4):
  - Stimulus: a load with no ack.
  - Response: `bus_timeout` pulse after 4 req cycles, rdata=0, core released.
  - Same stimulus with the macro undefined: stall persists.

Source files
------------

// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge
// Turns the core's level-held load/store strobes into one registered
// req/ack bus transaction per access. The core is held through stall_req
// until the access completes. The bridge produces byte enables and
// lane-replicated store data, and keeps the last read word registered.
// A simultaneous load+store runs the read first, then the write.
// Optional feature macro: LSU_BRIDGE_TIMEOUT_EN. When it is defined, a
// transaction that sees no bus_ack for TIMEOUT_CYCLES request cycles is
// force-completed and reports bus_timeout.
module lsu_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_sync,
    input  logic        access_ram_read,
    input  logic        access_ram_write,
    input  logic [1:0]  access_ram_write_width,
    input  logic [31:0] access_ram_raddr,
    input  logic [31:0] access_ram_waddr,
    input  logic [31:0] access_ram_wdata,
    output logic [31:0] access_ram_rdata,
    output logic        stall_req,
    input  logic        core_stall_n,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_timeout
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2, S_DONE = 2'd3} state_t;

    state_t      state_q;
    logic        wr_pend_q;
    logic [31:0] waddr_q;
    logic [31:0] wdata_q;
    logic [1:0]  wwidth_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_wdata_q;
    logic [31:0] rdata_q;
    logic        to_hit;
    logic        xfer_end;

    // Low address bits of a load are dropped: the core extracts the lane itself.
    logic unused_raddr_lo;
    assign unused_raddr_lo = &{1'b0, access_ram_raddr[1:0]};

    // Byte enables for a store; width 2'b11 is handled as a word.
    function automatic logic [3:0] be_f(input logic [1:0] width, input logic [1:0] lo);
        logic [3:0] be;
        case (width)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = 4'b0011 << {lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate right-justified store data onto every lane it may occupy.
    function automatic logic [31:0] wdata_f(input logic [1:0] width, input logic [31:0] d);
        logic [31:0] r;
        case (width)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

`ifdef LSU_BRIDGE_TIMEOUT_EN
    logic [15:0] to_cnt_q;
    logic        bus_timeout_q;

    // The count reaches TIMEOUT_CYCLES on this edge if another cycle goes unacked.
    assign to_hit = bus_req_q && !bus_ack && (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    // Count unacknowledged request cycles; restart for every new access.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            to_cnt_q      <= 16'd0;
            bus_timeout_q <= 1'b0;
        end else begin
            bus_timeout_q <= to_hit;
            if (state_q == S_IDLE || (state_q == S_RD && xfer_end)) begin
                to_cnt_q <= 16'd0;
            end else if (bus_req_q && !bus_ack) begin
                to_cnt_q <= to_cnt_q + 16'd1;
            end
        end
    end

    assign bus_timeout = bus_timeout_q;
`else
    localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
    assign to_hit      = 1'b0;
    assign bus_timeout = 1'b0;
`endif

    assign xfer_end = bus_req_q && (bus_ack || to_hit);

    // Stall the core from the strobe cycle until the bus side has finished.
    always_comb begin
        stall_req = 1'b0;
        case (state_q)
            S_IDLE:  stall_req = access_ram_read | access_ram_write;
            S_RD:    stall_req = 1'b1;
            S_WR:    stall_req = 1'b1;
            S_DONE:  stall_req = 1'b0;
            default: stall_req = 1'b0;
        endcase
    end

    // Access sequencer with registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q     <= S_IDLE;
            wr_pend_q   <= 1'b0;
            waddr_q     <= 32'd0;
            wdata_q     <= 32'd0;
            wwidth_q    <= 2'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (access_ram_read) begin
                        state_q    <= S_RD;
                        wr_pend_q  <= access_ram_write;
                        waddr_q    <= access_ram_waddr;
                        wdata_q    <= access_ram_wdata;
                        wwidth_q   <= access_ram_write_width;
                        bus_req_q  <= 1'b1;
                        bus_we_q   <= 1'b0;
                        bus_addr_q <= {access_ram_raddr[31:2], 2'b00};
                        bus_be_q   <= 4'b0000;
                    end else if (access_ram_write) begin
                        state_q     <= S_WR;
                        wr_pend_q   <= 1'b0;
                        waddr_q     <= access_ram_waddr;
                        wdata_q     <= access_ram_wdata;
                        wwidth_q    <= access_ram_write_width;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b1;
                        bus_addr_q  <= {access_ram_waddr[31:2], 2'b00};
                        bus_be_q    <= be_f(access_ram_write_width, access_ram_waddr[1:0]);
                        bus_wdata_q <= wdata_f(access_ram_write_width, access_ram_wdata);
                    end
                end
                S_RD: begin
                    if (xfer_end) begin
                        // A forced completion returns zero instead of stale bus data.
                        rdata_q <= bus_ack ? bus_rdata : 32'h0000_0000;
                        if (wr_pend_q) begin
                            // The store follows at once; the request stays up with new fields.
                            state_q     <= S_WR;
                            wr_pend_q   <= 1'b0;
                            bus_we_q    <= 1'b1;
                            bus_addr_q  <= {waddr_q[31:2], 2'b00};
                            bus_be_q    <= be_f(wwidth_q, waddr_q[1:0]);
                            bus_wdata_q <= wdata_f(wwidth_q, wdata_q);
                        end else begin
                            state_q   <= S_DONE;
                            bus_req_q <= 1'b0;
                        end
                    end
                end
                S_WR: begin
                    if (xfer_end) begin
                        state_q   <= S_DONE;
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        bus_be_q  <= 4'b0000;
                    end
                end
                S_DONE: begin
                    // The strobes are still high here; only a core advance re-arms IDLE.
                    if (core_stall_n) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    bus_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus_req          = bus_req_q;
    assign bus_we           = bus_we_q;
    assign bus_addr         = bus_addr_q;
    assign bus_be           = bus_be_q;
    assign bus_wdata        = bus_wdata_q;
    assign access_ram_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Testbench for lsu_bus_bridge: directed scenarios plus randomized accesses
// checked against a transaction-level timeline model of the bridge.
module tb_lsu_bus_bridge;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_sync;
    logic        access_ram_read, access_ram_write;
    logic [1:0]  access_ram_write_width;
    logic [31:0] access_ram_raddr, access_ram_waddr, access_ram_wdata;
    logic [31:0] access_ram_rdata;
    logic        stall_req, core_stall_n;
    logic        bus_req, bus_we, bus_ack, bus_timeout;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_rd = 32'd0;

    always #5 clk = ~clk;

    lsu_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_sync(rst_sync),
        .access_ram_read(access_ram_read), .access_ram_write(access_ram_write),
        .access_ram_write_width(access_ram_write_width),
        .access_ram_raddr(access_ram_raddr), .access_ram_waddr(access_ram_waddr),
        .access_ram_wdata(access_ram_wdata), .access_ram_rdata(access_ram_rdata),
        .stall_req(stall_req), .core_stall_n(core_stall_n),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .bus_timeout(bus_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_be(input logic [1:0] w, input logic [31:0] a);
        if (w == 2'd0) return 4'(32'd1 << (a % 32'd4));
        else if (w == 2'd1) return 4'(32'd3 << (a & 32'd2));
        else return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [1:0] w, input logic [31:0] d);
        if (w == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        else if (w == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        else return d;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req"},   32'(bus_req), 32'd0);
        check({tag, "_we"},    32'(bus_we), 32'd0);
        check({tag, "_be"},    32'(bus_be), 32'd0);
        check({tag, "_addr"},  bus_addr, 32'd0);
        check({tag, "_wdata"}, bus_wdata, 32'd0);
        check({tag, "_rdata"}, access_ram_rdata, 32'd0);
        check({tag, "_tmo"},   32'(bus_timeout), 32'd0);
        check({tag, "_stall"}, 32'(stall_req), 32'd0);
    endtask

    // One core access. The model lays out each bus access as a window of
    // (waits+1) request cycles, back to back, starting in cycle 1.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] ra, input logic [31:0] wa,
                           input logic [1:0] w, input logic [31:0] wd, input logic [31:0] rv,
                           input int waits_rd, input int waits_wr, input int ext);
        int st[2]; int en[2]; bit wex[2]; logic [31:0] ad[2]; logic [3:0] be[2];
        int n_acc, nxt, rd_ack, c_done, c_adv, cur;
        n_acc = 0; nxt = 1; rd_ack = -1;
        if (rd) begin
            st[n_acc] = nxt; en[n_acc] = nxt + waits_rd; wex[n_acc] = 1'b0;
            ad[n_acc] = ra & ~32'd3; be[n_acc] = 4'd0;
            rd_ack = en[n_acc]; nxt = en[n_acc] + 1; n_acc++;
        end
        if (wr) begin
            st[n_acc] = nxt; en[n_acc] = nxt + waits_wr; wex[n_acc] = 1'b1;
            ad[n_acc] = wa & ~32'd3; be[n_acc] = exp_be(w, wa);
            nxt = en[n_acc] + 1; n_acc++;
        end
        c_done = nxt;
        c_adv  = c_done + ext;
        for (int c = 0; c <= c_adv + 1; c++) begin
            @(negedge clk);
            access_ram_read        = rd && (c <= c_adv);
            access_ram_write       = wr && (c <= c_adv);
            access_ram_raddr       = ra;
            access_ram_waddr       = wa;
            access_ram_write_width = w;
            access_ram_wdata       = wd;
            core_stall_n           = (c >= c_adv);
            bus_ack                = 1'b0;
            bus_rdata              = $urandom;
            cur = -1;
            for (int j = 0; j < n_acc; j++) if (c >= st[j] && c <= en[j]) cur = j;
            if (cur >= 0 && c == en[cur]) begin
                bus_ack = 1'b1;
                if (!wex[cur]) bus_rdata = rv;
            end
            #1;
            check("stall", 32'(stall_req), 32'(c < c_done));
            check("req", 32'(bus_req), 32'(cur >= 0));
            if (cur >= 0) begin
                check("we", 32'(bus_we), 32'(wex[cur]));
                check("addr", bus_addr, ad[cur]);
                check("be", 32'(bus_be), 32'(be[cur]));
                if (wex[cur]) check("wdata", bus_wdata, exp_wd(w, wd));
            end
            if (rd_ack >= 0 && c == rd_ack + 1) last_rd = rv;
            check("rdata", access_ram_rdata, last_rd);
            check("tmo", 32'(bus_timeout), 32'd0);
        end
    endtask

    initial begin
        rst_sync = 1'b1; access_ram_read = 1'b0; access_ram_write = 1'b0;
        access_ram_write_width = 2'd0; access_ram_raddr = 32'd0; access_ram_waddr = 32'd0;
        access_ram_wdata = 32'd0; core_stall_n = 1'b1; bus_ack = 1'b0; bus_rdata = 32'd0;
        repeat (3) @(negedge clk);
        rst_sync = 1'b0;
        #1;
        check_idle_outputs("reset");

        // Zero-wait word load with an unaligned address.
        run_txn(1'b1, 1'b0, 32'h1000_0006, 32'd0, 2'd2, 32'd0, 32'hCAFE_F00D, 0, 0, 0);
        // Byte store to lane 3 with three wait states.
        run_txn(1'b0, 1'b1, 32'd0, 32'h0000_0013, 2'b00, 32'h0000_00A5, 32'd0, 0, 3, 0);
        // Simultaneous load + half store, zero-wait.
        run_txn(1'b1, 1'b1, 32'h20, 32'h24, 2'b01, 32'h1234_BEEF, 32'h5555_AAAA, 0, 0, 0);
        // External stall holds DONE for six cycles.
        run_txn(1'b1, 1'b0, 32'h40, 32'd0, 2'd2, 32'd0, 32'h0BAD_F00D, 1, 0, 6);
        // Width 2'b11 behaves as a word store; upper half store.
        run_txn(1'b0, 1'b1, 32'd0, 32'h0000_0102, 2'b11, 32'h89AB_CDEF, 32'd0, 0, 1, 2);
        run_txn(1'b0, 1'b1, 32'd0, 32'h0000_0206, 2'b01, 32'hFFFF_1357, 32'd0, 2, 0, 0);

        // Reset while a read is waiting on the slave.
        @(negedge clk);
        access_ram_read = 1'b1; access_ram_raddr = 32'h0000_0080; core_stall_n = 1'b0; bus_ack = 1'b0;
        @(negedge clk);
        #1 check("rst_mid_req", 32'(bus_req), 32'd1);
        @(negedge clk);
        rst_sync = 1'b1;
        @(negedge clk);
        rst_sync = 1'b0; access_ram_read = 1'b0; core_stall_n = 1'b1;
        #1;
        check_idle_outputs("rst_mid");
        last_rd = 32'd0;
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        #1 check("stray_req", 32'(bus_req), 32'd0);
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        check("stray_rdata", access_ram_rdata, 32'd0);
        check("stray_req2", 32'(bus_req), 32'd0);
        check("stray_stall", 32'(stall_req), 32'd0);

        // Load against a slave that never acknowledges.
        @(negedge clk);
        access_ram_read = 1'b1; access_ram_raddr = 32'h0000_0300; core_stall_n = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
`ifdef LSU_BRIDGE_TIMEOUT_EN
        for (int c = 1; c <= TO + 2; c++) begin
            @(negedge clk);
            access_ram_read = (c <= TO + 1);
            #1;
            check("to_req", 32'(bus_req), 32'(c <= TO));
            check("to_stall", 32'(stall_req), 32'(c <= TO));
            check("to_pulse", 32'(bus_timeout), 32'(c == TO + 1));
            if (c > TO) check("to_rdata", access_ram_rdata, 32'd0);
        end
        last_rd = 32'd0;
`else
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            #1;
            check("hung_req", 32'(bus_req), 32'd1);
            check("hung_stall", 32'(stall_req), 32'd1);
            check("hung_tmo", 32'(bus_timeout), 32'd0);
        end
        @(negedge clk);
        rst_sync = 1'b1;
        @(negedge clk);
        rst_sync = 1'b0; access_ram_read = 1'b0;
        #1 check("hung_recover", 32'(bus_req), 32'd0);
        last_rd = 32'd0;
`endif

        // Randomized accesses.
        for (int k = 0; k < 60; k++) begin
            bit rd, wr;
            int sel;
            sel = int'($urandom_range(0, 2));
            rd  = (sel != 1);
            wr  = (sel != 0);
            run_txn(rd, wr, $urandom, $urandom, 2'($urandom_range(0, 3)), $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
